// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-side bundle for the register file: read/write addresses,
// reservation and clear controls, and the read data and ready flags going back.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] Rs;
    logic [ADDR_W-1:0] Rt;
    logic [ADDR_W-1:0] Rd;
    logic [DATA_W-1:0] WriteData;
    logic              RegWrite;
    logic [ADDR_W-1:0] ResvAddr;
    logic              ResvEn;
    logic              ClearReq;
    logic [DATA_W-1:0] ReadRs;
    logic [DATA_W-1:0] ReadRt;
    logic              RsReady;
    logic              RtReady;
    logic              ClearBusy;

    modport master (
        output Rs, Rt, Rd, WriteData, RegWrite, ResvAddr, ResvEn, ClearReq,
        input  ReadRs, ReadRt, RsReady, RtReady, ClearBusy
    );

    modport slave (
        input  Rs, Rt, Rd, WriteData, RegWrite, ResvAddr, ResvEn, ClearReq,
        output ReadRs, ReadRt, RsReady, RtReady, ClearBusy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, write-to-read bypass,
// a per-register pending scoreboard and a one-entry-per-cycle clear sweep.
module regfile_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    regfile_scoreboard_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   ptr_reg, ptr_next;
    logic [DATA_W-1:0]   regs_reg [DEPTH];
    logic [DEPTH-1:0]    pend_reg;

    logic idle;
    logic sweeping;
    logic wr_eff;
    logic resv_eff;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (bus.ClearReq) begin
                    state_next = SWEEP;
                    ptr_next   = '0;
                end
            end
            SWEEP: begin
                ptr_next = ptr_reg + 1'b1;
                // Leave after clearing the last entry, not on pointer overflow.
                if (ptr_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        idle     = (state_reg == IDLE);
        sweeping = (state_reg == SWEEP);
    end

    assign bus.ClearBusy = sweeping;

    assign wr_eff   = bus.RegWrite && idle && !((ZERO_REG != 0) && (bus.Rd == '0));
    assign resv_eff = bus.ResvEn && idle && !((ZERO_REG != 0) && (bus.ResvAddr == '0));

    // The reservation set is issued after the write clear so that it wins.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
            pend_reg <= '0;
        end else if (sweeping) begin
            regs_reg[ptr_reg] <= '0;
            pend_reg[ptr_reg] <= 1'b0;
        end else begin
            if (wr_eff) begin
                regs_reg[bus.Rd] <= bus.WriteData;
                pend_reg[bus.Rd] <= 1'b0;
            end
            if (resv_eff) begin
                pend_reg[bus.ResvAddr] <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : port_g
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] data;
            logic              ready;
            logic              zero_hit;
            logic              fwd;

            assign addr     = (gi == 0) ? bus.Rs : bus.Rt;
            assign zero_hit = (ZERO_REG != 0) && (addr == '0);
            assign fwd      = (BYPASS != 0) && wr_eff && (bus.Rd == addr);

            always_comb begin
                data  = regs_reg[addr];
                ready = !pend_reg[addr];
                if (zero_hit) begin
                    data  = '0;
                    ready = 1'b1;
                end else if (fwd) begin
                    data  = bus.WriteData;
                    ready = 1'b1;
                end
            end
        end
    endgenerate

    assign bus.ReadRs  = port_g[0].data;
    assign bus.ReadRt  = port_g[1].data;
    assign bus.RsReady = port_g[0].ready;
    assign bus.RtReady = port_g[1].ready;
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised next-generation register file for the 16-bit CPU datapath. It provides configurable width, depth and hardwired-zero mode, with two combinational read ports and one write port. It adds same-cycle write-to-read bypass, a per-register pending scoreboard for multi-cycle producers, and a background clear sweep driven by a small state machine. It sits between decode (Rs/Rt/Rd) and writeback, replacing the fixed 4x16 register file.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 2, address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 0, 1 = register 0 always reads 0; writes and reservations to it are ignored
BYPASS, 1, 1 = a write in the current cycle is forwarded to matching read ports

Ports:
Clock  in  1  single clock, all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Rs  in  ADDR_W  read address A
Rt  in  ADDR_W  read address B
Rd  in  ADDR_W  write address
WriteData  in  DATA_W  write data
RegWrite  in  1  write enable
ResvAddr  in  ADDR_W  register to mark pending
ResvEn  in  1  reservation enable
ClearReq  in  1  one-cycle pulse that starts the clear sweep
ReadRs  out  DATA_W  data at Rs (combinational)
ReadRt  out  DATA_W  data at Rt (combinational)
RsReady  out  1  Rs value is valid (not pending)
RtReady  out  1  Rt value is valid (not pending)
ClearBusy  out  1  sweep in progress

Behaviour:
- Interface: one clock, Clock; Reset is synchronous and active-high; Reset has priority over every other input.
- On Reset: all registers = 0, all Pending = 0, FSM = IDLE, sweep pointer = 0. Outputs: ReadRs = ReadRt = 0, RsReady = RtReady = 1, ClearBusy = 0.
- Effective write (wr_eff) = RegWrite & FSM==IDLE & !(ZERO_REG & Rd==0). On wr_eff, reg[Rd] <= WriteData at the edge.
- Reads are combinational:
  - ZERO_REG & addr==0 -> 0.
  - Else, if BYPASS & wr_eff & Rd==addr -> WriteData.
  - Else -> reg[addr].
- Scoreboard, Pending[DEPTH]:
  - On wr_eff, Pending[Rd] <= 0.
  - On ResvEn & FSM==IDLE & !(ZERO_REG & ResvAddr==0), Pending[ResvAddr] <= 1.
  - ResvEn and wr_eff to the same address in the same cycle: the set wins, and Pending ends at 1.
- RsReady = !Pending[Rs] | (BYPASS & wr_eff & Rd==Rs). RtReady follows the same rule for Rt. Register 0 under ZERO_REG is always ready.
- FSM states:
  - IDLE: ClearReq -> SWEEP with ptr = 0. A RegWrite in the same cycle as ClearReq still executes, and the sweep later clears it.
  - SWEEP: each cycle reg[ptr] <= 0, Pending[ptr] <= 0, ptr <= ptr+1. At ptr == DEPTH-1 the state returns to IDLE after clearing that entry. The sweep takes exactly DEPTH cycles.
- ClearBusy = (FSM==SWEEP).
- During SWEEP:
  - RegWrite, ResvEn and ClearReq are ignored.
  - Bypass is disabled.
  - Reads return the current stored contents; cleared entries read 0.
- Reset during SWEEP aborts it at once: everything is zeroed and the next state is IDLE.
- Pointer wrap: ptr is ADDR_W bits wide and wraps naturally. The exit condition is ptr == DEPTH-1, not the overflow.
- Rs == Rt is legal; both ports return the same value and the same ready status.

Test Plan:
- Reset, then write 0xBEEF to R2, then read Rs=Rt=2 next cycle -> ReadRs = ReadRt = 0xBEEF. All other registers read 0; RsReady = RtReady = 1.
- BYPASS=1: in one cycle, RegWrite with Rd=1, WriteData=0x1234, Rs=1 -> ReadRs = 0x1234 in the same cycle. With BYPASS=0 the same cycle gives the old value 0x0000, and 0x1234 appears the next cycle.
- ResvEn with ResvAddr=3 -> next cycle Rs=3 gives RsReady = 0. Then write 0x00AA to R3 -> RsReady = 1 in that cycle (bypass) and after it. Simultaneous ResvEn=3 and write Rd=3 -> Pending stays 1 and RsReady = 0 next cycle.
- ZERO_REG=1: write 0xFFFF to R0 and ResvEn to R0 -> R0 reads 0 and RsReady = 1. R1 is unaffected.
- Load R0..R3 with 0x11, 0x22, 0x33, 0x44 and reserve R2, then pulse ClearReq -> ClearBusy = 1 for exactly 4 cycles, and R0..R3 read 0 in that order one per cycle. A RegWrite to R1 during the sweep is ignored. Afterwards all registers are 0 and all ready.
- Assert Reset on sweep cycle 2 -> next cycle ClearBusy = 0 and all registers are 0. A new ClearReq restarts the sweep from ptr = 0 and again lasts 4 cycles.
